// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if
//   Bundles the requester side and the I2C-controller side of the arbiter.
//   Requester side : req, req_dev_addr (8 bits per requester),
//                    req_reg_data (16 bits per requester), grant, done, nack.
//   Controller side: ctl_start, ctl_dev_addr, ctl_reg_data, ctl_ready, ctl_ack.
//   modport master : the arbiter's view (drives grant/done/nack and ctl_*
//                    strobes/data, samples requests and controller status).
//   modport slave  : the environment's view (requesters plus controller).
interface i2c_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req;
  logic [8*NREQ-1:0]  req_dev_addr;
  logic [16*NREQ-1:0] req_reg_data;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    nack;
  logic               ctl_start;
  logic [7:0]         ctl_dev_addr;
  logic [15:0]        ctl_reg_data;
  logic               ctl_ready;
  logic               ctl_ack;

  modport master (
    input  req, req_dev_addr, req_reg_data, ctl_ready, ctl_ack,
    output grant, done, nack, ctl_start, ctl_dev_addr, ctl_reg_data
  );

  modport slave (
    output req, req_dev_addr, req_reg_data, ctl_ready, ctl_ack,
    input  grant, done, nack, ctl_start, ctl_dev_addr, ctl_reg_data
  );
endinterface

// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Shares one I2C register-write controller between NREQ requesters with
//   round-robin arbitration, NACK retries and a per-phase timeout.
//   Ports:
//     clk         : controller clock, all logic on its rising edge
//     reset       : synchronous, active-high
//     bus         : i2c_arbiter_if.master (requests, grant/done/nack, ctl_*)
//     busy        : high whenever the FSM is not idle
//     timeout_err : sticky, set on any START / WAIT_DONE timeout
module i2c_arbiter #(
  parameter int NREQ      = 3,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            reset,
  i2c_arbiter_if.master   bus,
  output logic            busy,
  output logic            timeout_err
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);
  localparam logic [CNTW:0]   TO_LIM    = (CNTW + 1)'(TIMEOUT);
  localparam logic [RW-1:0]   RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [IDXW-1:0] LAST_RST  = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] nack_q, nack_d;
  logic            start_q, start_d;
  logic [7:0]      addr_q, addr_d;
  logic [15:0]     data_q, data_d;
  logic [IDXW-1:0] winner_q, winner_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic            terr_q, terr_d;

  logic            found;
  logic [IDXW-1:0] pick;
  logic            cnt_hit;

  // Timeout fires on the TIMEOUT-th cycle spent in the current phase.
  assign cnt_hit = (({1'b0, cnt_q} + 1'b1) == TO_LIM);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    nack_d   = '0;
    start_d  = start_q;
    addr_d   = addr_q;
    data_d   = data_q;
    winner_d = winner_q;
    last_d   = last_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    terr_d   = terr_q;
    found    = 1'b0;
    pick     = '0;

    // Round-robin search starting just after the previous owner.
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[(int'(last_q) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IDXW'((int'(last_q) + k) % NREQ);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.ctl_ready && found) begin
          winner_d       = pick;
          grant_d        = '0;
          grant_d[pick]  = 1'b1;
          addr_d         = bus.req_dev_addr[pick*8 +: 8];
          data_d         = bus.req_reg_data[pick*16 +: 16];
          retry_d        = '0;
          cnt_d          = '0;
          start_d        = 1'b1;
          state_d        = S_START;
        end
      end

      S_START: begin
        if (!bus.ctl_ready) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_hit) begin
          start_d = 1'b0;
          done_d  = grant_q;
          nack_d  = grant_q;
          terr_d  = 1'b1;
          grant_d = '0;
          last_d  = winner_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (bus.ctl_ready) begin
          ack_d   = bus.ctl_ack;
          state_d = S_RESULT;
        end else if (cnt_hit) begin
          done_d  = grant_q;
          nack_d  = grant_q;
          terr_d  = 1'b1;
          grant_d = '0;
          last_d  = winner_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESULT: begin
        if (ack_q) begin
          done_d  = grant_q;
          grant_d = '0;
          last_d  = winner_q;
          state_d = S_IDLE;
        end else if (retry_q < RETRY_LIM) begin
          retry_d = retry_q + 1'b1;
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = S_START;
        end else begin
          // Failed owners also advance the pointer so a NACKing device
          // cannot monopolise the controller.
          done_d  = grant_q;
          nack_d  = grant_q;
          grant_d = '0;
          last_d  = winner_q;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      nack_q   <= '0;
      start_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      winner_q <= '0;
      last_q   <= LAST_RST;
      retry_q  <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
      start_q  <= start_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      terr_q   <= terr_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.nack         = nack_q;
  assign bus.ctl_start    = start_q;
  assign bus.ctl_dev_addr = addr_q;
  assign bus.ctl_reg_data = data_q;
  assign busy             = (state_q != S_IDLE);
  assign timeout_err      = terr_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter
//   Directed scoreboard bench for i2c_arbiter (NREQ=3, MAX_RETRY=2,
//   TIMEOUT=255). A behavioural I2C controller answers ctl_start; a monitor
//   pops expected grants and done records whenever the DUT presents them.
module tb_i2c_arbiter;
  localparam int NREQ = 3;

  typedef struct packed {
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] nack;
    logic [7:0]      addr;
    logic [15:0]     data;
  } done_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic timeout_err;

  done_t           exp_done_q[$];
  logic [NREQ-1:0] exp_grant_q[$];
  bit              ack_script[$];
  bit              hang = 1'b0;
  int              starts_seen = 0;
  int              n_compared = 0;
  int              n_mismatched = 0;

  always #5 clk = ~clk;

  i2c_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_arbiter #(
    .NREQ(NREQ),
    .MAX_RETRY(2),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r);
    bus.req = r;
  endtask

  task automatic setReq(input int i, input logic [7:0] a, input logic [15:0] d);
    bus.req_dev_addr[i*8 +: 8]   = a;
    bus.req_reg_data[i*16 +: 16] = d;
  endtask

  task automatic expectDone(input logic [NREQ-1:0] d, input logic [NREQ-1:0] n,
                            input logic [7:0] a, input logic [15:0] dat);
    done_t e;
    e.done = d;
    e.nack = n;
    e.addr = a;
    e.data = dat;
    exp_done_q.push_back(e);
  endtask

  // Waits for a done pulse, counting cycles with ctl_start high meanwhile.
  task automatic waitForDone(input int limit, output int start_cycles);
    start_cycles = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.ctl_start) start_cycles++;
      if (bus.done != '0) return;
    end
    checkOutput("done_wait_expired", 32'd0, 32'd1);
  endtask

  // Waits until the transfer is under way (controller busy, strobe dropped).
  task automatic waitWaitDone(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy && !bus.ctl_start && !bus.ctl_ready) return;
    end
    checkOutput("wait_done_expired", 32'd0, 32'd1);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural controller: accepts a start, stays busy three cycles, then
  // returns the next scripted ack (default ACK). In hang mode it never reacts.
  initial begin
    bus.ctl_ready = 1'b1;
    bus.ctl_ack   = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.ctl_start && bus.ctl_ready && !hang) begin
        starts_seen++;
        bus.ctl_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.ctl_ack   = (ack_script.size() != 0) ? ack_script.pop_front() : 1'b1;
        bus.ctl_ready = 1'b1;
      end
    end
  end

  // Monitor: every new grant and every done/nack pulse is scored.
  initial begin
    logic [NREQ-1:0] prev_grant;
    done_t e;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.grant != '0 && bus.grant != prev_grant) begin
        checkOutput("grant_gap", 32'(prev_grant), 32'd0);
        if (exp_grant_q.size() == 0)
          checkOutput("grant_unexpected", 32'(bus.grant), 32'd0);
        else
          checkOutput("grant_owner", 32'(bus.grant), 32'(exp_grant_q.pop_front()));
      end
      prev_grant = bus.grant;
      if (bus.done != '0 || bus.nack != '0) begin
        if (exp_done_q.size() == 0) begin
          checkOutput("done_unexpected", 32'({bus.done, bus.nack}), 32'd0);
        end else begin
          e = exp_done_q.pop_front();
          checkOutput("done_vec", 32'(bus.done), 32'(e.done));
          checkOutput("nack_vec", 32'(bus.nack), 32'(e.nack));
          checkOutput("done_addr", 32'(bus.ctl_dev_addr), 32'(e.addr));
          checkOutput("done_data", 32'(bus.ctl_reg_data), 32'(e.data));
          checkOutput("done_grant_clear", 32'(bus.grant), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc;
    bus.req          = '0;
    bus.req_dev_addr = '0;
    bus.req_reg_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("rst_done_nack", 32'({bus.done, bus.nack}), 32'd0);
    checkOutput("rst_ctl_start", 32'(bus.ctl_start), 32'd0);
    checkOutput("rst_ctl_addr", 32'(bus.ctl_dev_addr), 32'd0);
    checkOutput("rst_ctl_data", 32'(bus.ctl_reg_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // Single ACKed transfer from requester 0
    setReq(0, 8'h72, 16'h9803);
    exp_grant_q.push_back(3'b001);
    expectDone(3'b001, 3'b000, 8'h72, 16'h9803);
    starts_seen = 0;
    applyStimulus(3'b001);
    waitForDone(100, sc);
    applyStimulus(3'b000);
    checkOutput("t1_start_cycles", 32'(sc), 32'd1);
    checkOutput("t1_starts", 32'(starts_seen), 32'd1);

    // All three held: round-robin 0,1,2,0 from reset
    applyReset();
    setReq(1, 8'h11, 16'h1111);
    setReq(2, 8'h22, 16'h2222);
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b010);
    exp_grant_q.push_back(3'b100);
    exp_grant_q.push_back(3'b001);
    expectDone(3'b001, 3'b000, 8'h72, 16'h9803);
    expectDone(3'b010, 3'b000, 8'h11, 16'h1111);
    expectDone(3'b100, 3'b000, 8'h22, 16'h2222);
    expectDone(3'b001, 3'b000, 8'h72, 16'h9803);
    applyStimulus(3'b111);
    for (int i = 0; i < 4; i++) waitForDone(100, sc);
    applyStimulus(3'b000);

    // Requester 1 NACKed three times: two retries then nack
    exp_grant_q.push_back(3'b010);
    expectDone(3'b010, 3'b010, 8'h11, 16'h1111);
    repeat (3) ack_script.push_back(1'b0);
    starts_seen = 0;
    applyStimulus(3'b010);
    waitForDone(200, sc);
    applyStimulus(3'b000);
    checkOutput("retry_starts", 32'(starts_seen), 32'd3);
    checkOutput("retry_start_cycles", 32'(sc), 32'd3);

    // Requester 2 with a controller that never goes busy: START timeout
    hang = 1'b1;
    exp_grant_q.push_back(3'b100);
    expectDone(3'b100, 3'b100, 8'h22, 16'h2222);
    applyStimulus(3'b100);
    waitForDone(400, sc);
    applyStimulus(3'b000);
    checkOutput("to_start_cycles", 32'(sc), 32'd255);
    checkOutput("to_ctl_start", 32'(bus.ctl_start), 32'd0);
    checkOutput("to_err_set", 32'(timeout_err), 32'd1);
    hang = 1'b0;

    // Request data changed mid-transfer must not reach the controller
    setReq(0, 8'h50, 16'h0100);
    exp_grant_q.push_back(3'b001);
    expectDone(3'b001, 3'b000, 8'h50, 16'h0100);
    applyStimulus(3'b001);
    waitWaitDone(50);
    setReq(0, 8'h50, 16'h0218);
    waitForDone(100, sc);
    applyStimulus(3'b000);
    checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT_DONE aborts silently; requester 0 then wins first
    exp_grant_q.push_back(3'b010);
    applyStimulus(3'b010);
    waitWaitDone(50);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("mid_rst_ctl_start", 32'(bus.ctl_start), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    exp_grant_q.push_back(3'b001);
    expectDone(3'b001, 3'b000, 8'h50, 16'h0218);
    applyStimulus(3'b011);
    waitForDone(100, sc);
    applyStimulus(3'b000);

    repeat (10) @(negedge clk);
    checkOutput("grant_queue_empty", 32'(exp_grant_q.size()), 32'd0);
    checkOutput("done_queue_empty", 32'(exp_done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters, range 2..8.
REQ-002 Parameter MAX_RETRY, default 2: re-launches after a NACK before the error is reported.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles spent waiting in START or WAIT_DONE.
REQ-004 Port clk, input, 1: same clock as the I2C controller (divided I2C clock); all logic is on its rising edge.
REQ-005 Port reset, input, 1: reset reset, synchronous, active-high.
REQ-006 Port req, input, NREQ: per-requester transaction request; the requester holds it high until its done pulse.
REQ-007 Port req_dev_addr, input, 8*NREQ: packed device address; slice i belongs to requester i.
REQ-008 Port req_reg_data, input, 16*NREQ: packed {register, value}; slice i belongs to requester i.
REQ-009 Port grant, output, NREQ: one-hot (or zero) owner of the controller.
REQ-010 Port done, output, NREQ: 1-cycle pulse to the owner when its transaction ends.
REQ-011 Port nack, output, NREQ: 1-cycle pulse, coincident with done, when the transaction failed.
REQ-012 Port ctl_start, output, 1: start strobe to the I2C controller.
REQ-013 Port ctl_dev_addr, output, 8: device address to the controller.
REQ-014 Port ctl_reg_data, output, 16: register/data word to the controller.
REQ-015 Port ctl_ready, input, 1: controller idle; low while a transfer is in progress.
REQ-016 Port ctl_ack, input, 1: high means the slave acknowledged; valid whenever ctl_ready is high.
REQ-017 Port busy, output, 1: high in any state other than IDLE.
REQ-018 Port timeout_err, output, 1: sticky flag; set on any timeout, cleared only by reset.

Function
REQ-019 The FSM shall have the states IDLE, START, WAIT_DONE and RESULT.
REQ-020 IDLE: when ctl_ready=1 and req!=0, the block selects a winner, registers its address and data onto ctl_dev_addr/ctl_reg_data, sets grant[winner], clears the retry count, and moves to START on the next cycle.
REQ-021 Winner selection shall be round-robin: the search starts at the index after last_winner and wraps from NREQ-1 to 0; after reset, last_winner=NREQ-1, so requester 0 has first priority.
REQ-022 ctl_dev_addr and ctl_reg_data shall stay stable from grant until the return to IDLE; later changes on req_* inputs are ignored.
REQ-023 START: ctl_start=1; when ctl_ready=0 is sampled, ctl_start drops and the FSM moves to WAIT_DONE on the next edge.
REQ-024 WAIT_DONE: on ctl_ready=1, ctl_ack is sampled and the FSM moves to RESULT.
REQ-025 RESULT, ack=1: pulse done[winner], clear grant, set last_winner=winner, go to IDLE.
REQ-026 RESULT, ack=0 with retry<MAX_RETRY: increment retry, keep grant, return to START.
REQ-027 RESULT, ack=0 with retry=MAX_RETRY: pulse done[winner] and nack[winner], clear grant, go to IDLE.
REQ-028 A cycle counter shall clear on entry to START and WAIT_DONE; when it reaches TIMEOUT, the block drops ctl_start, pulses done[winner] and nack[winner], sets timeout_err, clears grant, and goes to IDLE. No retry follows a timeout.
REQ-029 If a requester drops req mid-transaction, the transaction still completes and done still pulses.
REQ-030 A requester that holds req through done competes again in the next IDLE arbitration; it shall not be granted twice in a row while others are requesting.
REQ-031 Between successive grants, at least one IDLE cycle shall occur with grant=0.
REQ-032 When IDLE sees ctl_ready=0, no grant is issued until ctl_ready=1.
REQ-033 At most one bit of grant, done and nack shall be high at any time.

Reset
REQ-034 Reset shall drive the FSM to IDLE and set grant=0, done=0, nack=0, ctl_start=0, ctl_dev_addr=0, ctl_reg_data=0, busy=0, timeout_err=0, retry=0 and last_winner=NREQ-1.
REQ-035 Reset mid-transfer shall drop ctl_start on the next edge; no done pulse is emitted for the aborted transaction.

Verification
REQ-036 req=3'b001, addr0=0x72, data0=0x9803, slave ACKs -> grant=001; ctl_start high until ctl_ready falls; done[0] pulses; nack=0.
REQ-037 req=3'b111 held continuously, all ACK -> grant order 0,1,2,0 with one grant=0 cycle between grants.
REQ-038 Requester 1 request, ctl_ack=0 three times (MAX_RETRY=2) -> three ctl_start assertions, then done[1] and nack[1] pulse together.
REQ-039 Requester 2 request, ctl_ready never falls -> after 255 START cycles, ctl_start=0, done[2] and nack[2] pulse, and timeout_err=1 sticks.
REQ-040 reset asserted during WAIT_DONE -> next edge: grant=0, ctl_start=0, busy=0, no done pulse; with req=001, requester 0 wins first.
REQ-041 req_reg_data0 changed from 0x0100 to 0x0218 during WAIT_DONE -> ctl_reg_data stays at 0x0100 through done.
